// File: rtl/nco_pkg.sv
// nco_pkg: shared types and default widths for the NCO/LUT scheduler.
//   nco_state_e  - sweep FSM state (IDLE, ADDR, OUT)
//   NCO_*        - default parameter values used by nco_lut_sched / phase_acc
package nco_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_OUT  = 2'd2
   } nco_state_e;

   localparam int NCO_NUM_CH   = 4;
   localparam int NCO_PHASE_W  = 24;
   localparam int NCO_ROM_AW   = 8;
   localparam int NCO_OUT_W    = 12;

endpackage

// File: rtl/nco_lut_sched_phase_acc.sv
// phase_acc: one channel's phase accumulator.
//   clk, rst     - clock, async active-high reset
//   tick         - sample strobe; advances or clears the accumulator
//   enable       - channel enable; a disabled channel clears on tick
//   ftw          - frequency tuning word added per tick
//   phase        - accumulator value (wraps modulo 2^PHASE_WIDTH)
module phase_acc
   import nco_pkg::*;
#(
   parameter int PHASE_WIDTH = NCO_PHASE_W
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   tick,
   input  logic                   enable,
   input  logic [PHASE_WIDTH-1:0] ftw,
   output logic [PHASE_WIDTH-1:0] phase
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         phase <= '0;
      else if (tick)
         phase <= enable ? phase + ftw : '0;
   end

endmodule

// File: rtl/nco_lut_sched.sv
// nco_lut_sched: NUM_CH NCO channels time-sharing one external sine LUT.
// Each tick advances every channel's accumulator and (if idle) starts a sweep
// that emits one sample per enabled channel, lowest channel first.
//   clk, rst            - clock, async active-high reset
//   tick                - sample strobe, starts a sweep when idle
//   ch_en               - per-channel enable (latched as sweep mask)
//   cfg_we/ch/ftw/pow   - per-channel tuning word / phase offset write
//   lut_addr, lut_data  - shared combinational sine LUT port
//   out_valid/ready     - sample handshake; out_ch/out_data sample payload
//   overrun             - pulse when a tick arrives mid-sweep
module nco_lut_sched
   import nco_pkg::*;
#(
   parameter int  NUM_CH         = NCO_NUM_CH,
   parameter int  PHASE_WIDTH    = NCO_PHASE_W,
   parameter int  ROM_ADDR_WIDTH = NCO_ROM_AW,
   parameter int  OUTPUT_WIDTH   = NCO_OUT_W,
   localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
)(
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           tick,
   input  logic [NUM_CH-1:0]              ch_en,
   input  logic                           cfg_we,
   input  logic [CH_W-1:0]                cfg_ch,
   input  logic [PHASE_WIDTH-1:0]         cfg_ftw,
   input  logic [ROM_ADDR_WIDTH-1:0]      cfg_pow,
   output logic [ROM_ADDR_WIDTH-1:0]      lut_addr,
   input  logic signed [OUTPUT_WIDTH-1:0] lut_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [CH_W-1:0]                out_ch,
   output logic signed [OUTPUT_WIDTH-1:0] out_data,
   output logic                           overrun
);

   logic [NUM_CH-1:0][PHASE_WIDTH-1:0]    r_ftw;
   logic [NUM_CH-1:0][ROM_ADDR_WIDTH-1:0] r_pow;
   logic [NUM_CH-1:0][PHASE_WIDTH-1:0]    w_phase;
   logic [NUM_CH-1:0]                     w_cfg_hit;

   nco_state_e                            r_state, w_state_nxt;
   logic [NUM_CH-1:0]                     r_mask;
   logic [CH_W-1:0]                       r_ch, w_ch_nxt;
   logic [CH_W-1:0]                       w_first_ch, w_next_ch;
   logic                                  w_next_vld;
   logic                                  w_start;
   logic [PHASE_WIDTH-1:0]                w_cur_phase;
   logic [ROM_ADDR_WIDTH-1:0]             w_cur_addr;

   logic signed [OUTPUT_WIDTH-1:0]        r_out_data;
   logic [CH_W-1:0]                       r_out_ch;
   logic                                  r_overrun;

   // per-channel config decode and accumulators
   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      assign w_cfg_hit[g] = cfg_we && (cfg_ch == CH_W'(g));

      phase_acc #(.PHASE_WIDTH(PHASE_WIDTH)) u_acc (
         .clk    (clk),
         .rst    (rst),
         .tick   (tick),
         .enable (ch_en[g]),
         .ftw    (r_ftw[g]),
         .phase  (w_phase[g])
      );
   end

   // ftw is registered, so a tick coinciding with a write uses the old value
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ftw <= '0;
         r_pow <= '0;
      end else begin
         for (int c = 0; c < NUM_CH; c++) begin
            if (w_cfg_hit[c]) begin
               r_ftw[c] <= cfg_ftw;
               r_pow[c] <= cfg_pow;
            end
         end
      end
   end

   // lowest enabled channel for a new sweep; next higher mask bit mid-sweep
   always_comb begin
      w_first_ch = '0;
      w_next_ch  = '0;
      w_next_vld = 1'b0;
      for (int c = NUM_CH-1; c >= 0; c--) begin
         if (ch_en[c])
            w_first_ch = CH_W'(c);
         if (r_mask[c] && (CH_W'(c) > r_ch)) begin
            w_next_vld = 1'b1;
            w_next_ch  = CH_W'(c);
         end
      end
   end

   assign w_start     = (r_state == ST_IDLE) && tick && (|ch_en);
   assign w_cur_phase = w_phase[r_ch];
   assign w_cur_addr  = w_cur_phase[PHASE_WIDTH-1 -: ROM_ADDR_WIDTH] + r_pow[r_ch];

   always_comb begin
      w_state_nxt = r_state;
      w_ch_nxt    = r_ch;
      case (r_state)
         ST_IDLE: begin
            if (w_start) begin
               w_state_nxt = ST_ADDR;
               w_ch_nxt    = w_first_ch;
            end
         end
         ST_ADDR: w_state_nxt = ST_OUT;
         ST_OUT: begin
            if (out_ready) begin
               if (w_next_vld) begin
                  w_state_nxt = ST_ADDR;
                  w_ch_nxt    = w_next_ch;
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_ch       <= '0;
         r_mask     <= '0;
         r_out_data <= '0;
         r_out_ch   <= '0;
         r_overrun  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_ch      <= w_ch_nxt;
         r_overrun <= tick && (r_state != ST_IDLE);
         if (w_start)
            r_mask <= ch_en;
         if (r_state == ST_ADDR) begin
            r_out_data <= lut_data;
            r_out_ch   <= r_ch;
         end
      end
   end

   // address only driven while fetching; 0 otherwise
   assign lut_addr  = (r_state == ST_ADDR) ? w_cur_addr : '0;
   assign out_valid = (r_state == ST_OUT);
   assign out_ch    = r_out_ch;
   assign out_data  = r_out_data;
   assign overrun   = r_overrun;

endmodule

// File: doc/nco_lut_sched.md
NCO_LUT_SCHED -- requirements
Module: nco_lut_sched

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of NCO channels sharing one sine_lut.
REQ-002 SHALL have parameter PHASE_WIDTH, default 24: phase accumulator width.
REQ-003 SHALL have parameter ROM_ADDR_WIDTH, default 8: sine_lut address width.
REQ-004 SHALL have parameter OUTPUT_WIDTH, default 12: signed sample width.
REQ-005 SHALL have port clk  input  1: single clock, rising edge.
REQ-006 SHALL have port rst  input  1: asynchronous, active-high reset.
REQ-007 SHALL have port tick  input  1: one-cycle sample strobe starting a sweep.
REQ-008 SHALL have port ch_en  input  NUM_CH: per-channel enable.
REQ-009 SHALL have port cfg_we  input  1: configuration write strobe.
REQ-010 SHALL have port cfg_ch  input  clog2(NUM_CH): channel targeted by cfg_we.
REQ-011 SHALL have port cfg_ftw  input  PHASE_WIDTH: frequency tuning word.
REQ-012 SHALL have port cfg_pow  input  ROM_ADDR_WIDTH: phase offset word.
REQ-013 SHALL have port lut_addr  output  ROM_ADDR_WIDTH: address to the shared sine_lut.
REQ-014 SHALL have port lut_data  input  OUTPUT_WIDTH signed: combinational sine_lut result.
REQ-015 SHALL have port out_valid  output  1, out_ready  input  1: sample handshake.
REQ-016 SHALL have port out_ch  output  clog2(NUM_CH), out_data  output  OUTPUT_WIDTH signed: sample channel and value.
REQ-017 SHALL have port overrun  output  1: one-cycle pulse on tick during active sweep.

Function
REQ-018 SHALL hold per channel: ftw, pow, accumulator (PHASE_WIDTH, unsigned, wraps modulo 2^PHASE_WIDTH).
REQ-019 cfg_we SHALL write cfg_ftw/cfg_pow into channel cfg_ch at the clock edge; a tick in the same cycle uses the old ftw.
REQ-020 On tick, each enabled channel SHALL add ftw to its accumulator; each disabled channel SHALL clear its accumulator to 0; this applies whether or not a sweep is active.
REQ-021 FSM states SHALL be IDLE, ADDR, OUT.
REQ-022 IDLE: on tick with any ch_en bit set, SHALL latch ch_en as sweep mask and go to ADDR with channel = lowest set bit; with ch_en=0 SHALL stay IDLE.
REQ-023 ADDR: lut_addr SHALL equal accumulator[MSB -: ROM_ADDR_WIDTH] + pow (modulo 2^ROM_ADDR_WIDTH) of the current channel; at the edge SHALL register lut_data into out_data, channel into out_ch, go to OUT.
REQ-024 OUT: out_valid=1; out_data/out_ch SHALL stay stable until out_valid&&out_ready.
REQ-025 On handshake SHALL go to ADDR with next higher set bit of the latched mask, or IDLE if none.
REQ-026 Latency: tick at cycle T SHALL give out_valid at T+2 for the first channel; with out_ready held 1, one sample every 2 cycles.
REQ-027 A tick while not IDLE SHALL NOT restart the sweep and SHALL pulse overrun for one cycle; the in-flight sweep continues with updated accumulators.
REQ-028 In IDLE, lut_addr SHALL be 0.
REQ-029 ch_en changes mid-sweep SHALL NOT affect the latched mask.

Reset
REQ-030 rst SHALL asynchronously force state IDLE, all ftw/pow/accumulators 0, out_valid 0, out_data 0, out_ch 0, overrun 0, lut_addr 0.
REQ-031 rst asserted mid-sweep SHALL abandon the sweep; no sample SHALL appear after deassertion until a new tick.

Structure
REQ-032 Shared package nco_pkg SHALL hold the FSM state enum and default width constants.
REQ-033 Per-channel accumulator SHALL be sub-module phase_acc (tick, enable, ftw in; phase out), instantiated NUM_CH times; sine_lut SHALL stay external.

Verification
REQ-034 ch0 ftw=0x400000, pow=0, ch_en=0001, out_ready=1, four ticks -> out_data 2047, 0, -2047, 0 on out_ch 0.
REQ-035 ch0 ftw=0, pow=64; ch2 ftw=0, pow=192; ch_en=0101, one tick -> samples (ch0, 2047) at T+2, then (ch2, -2047) at T+4, then IDLE.
REQ-036 out_ready=0 for 5 cycles during OUT -> out_valid held, out_data/out_ch unchanged, next sample only after handshake.
REQ-037 ch_en=1111, out_ready=0, tick every 3 cycles -> overrun pulses on each tick after the first; accumulators still advance.
REQ-038 ch0 ftw=0xFFFFFF, two ticks -> accumulator wraps to 0xFFFFFE, lut_addr 255 both times.
REQ-039 rst asserted while in OUT -> out_valid 0 immediately, all state cleared, no output until next tick.
